apb_node_watchdog: RTL
======================

// Module: apb_node_watchdog
// PURPOSE
//  Parametrised APB 1-to-NB_MASTER peripheral node, successor to the fixed peripheral bus wrapper.
//  Decodes the upstream APB access against per-port address ranges and replays it on one downstream port through a registered stage.
//  Adds a per-access PREADY watchdog and a default error slave for unmapped addresses.
//  Keeps sticky error status for the SoC controller.
// PARAMETERS
//  NB_MASTER       9             number of downstream APB ports (1..32)
//  APB_ADDR_WIDTH  32            address width
//  APB_DATA_WIDTH  32            data width
//  TIMEOUT_CYCLES  256           max ACCESS cycles waiting for PREADY; 0 = watchdog disabled
//  ERR_RDATA       32'hDEAD_BEEF prdata_o returned on decode/timeout error (truncated to DW)
// PORTS
//  clk_i         in   1            clock
//  rst_ni        in   1            async reset, active low
//  paddr_i       in   AW           upstream address
//  pwdata_i      in   DW           upstream write data
//  pwrite_i      in   1            upstream write
//  psel_i        in   1            upstream select
//  penable_i     in   1            upstream enable
//  prdata_o      out  DW           upstream read data
//  pready_o      out  1            upstream ready
//  pslverr_o     out  1            upstream error
//  start_addr_i  in   NBxAW        per-port range start (inclusive)
//  end_addr_i    in   NBxAW        per-port range end (inclusive)
//  paddr_o       out  AW           downstream address (shared, registered)
//  pwdata_o      out  DW           downstream write data (shared, registered)
//  pwrite_o      out  1            downstream write (shared, registered)
//  psel_o        out  NB           downstream one-hot select
//  penable_o     out  1            downstream enable (shared)
//  prdata_i      in   NBxDW        downstream read data
//  pready_i      in   NB           downstream ready
//  pslverr_i     in   NB           downstream error
//  err_valid_o   out  1            sticky error flag
//  err_type_o    out  1            0 = decode miss, 1 = timeout
//  err_addr_o    out  AW           address of first unacknowledged error
//  err_clr_i     in   1            clears err_valid_o (single-cycle pulse)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counter 0. Reset mid-transfer aborts silently; no response is given.
//  Decode is combinational on paddr_i: hit[i] = start_addr_i[i] <= paddr_i <= end_addr_i[i].
//   Lowest index wins on overlap.
//  FSM:
//   IDLE: on psel_i & !penable_i, latch addr/wdata/write and idx.
//    Any hit -> DSETUP. No hit -> RESP with error, err_type=0.
//   DSETUP: psel_o[idx]=1, penable_o=0. Next cycle -> DACCESS, counter=0.
//   DACCESS: psel_o[idx]=1, penable_o=1.
//    pready_i[idx]: capture prdata_i[idx]/pslverr_i[idx], drop psel_o/penable_o, -> RESP.
//    Else if TIMEOUT_CYCLES!=0 && counter==TIMEOUT_CYCLES-1: drop psel_o/penable_o, -> RESP with error, err_type=1.
//    Else counter++ (saturating width $clog2(TIMEOUT_CYCLES+1)).
//   RESP: pready_o=1 for exactly one cycle, then -> IDLE.
//    prdata_o = captured data, or ERR_RDATA on error. pslverr_o = captured error or 1.
//    prdata_o/pslverr_o are 0 whenever pready_o=0.
//  Latency: zero-wait slave gives upstream pready_o in the 3rd cycle after setup.
//   Each downstream wait state adds 1 cycle. Decode miss: pready_o in the cycle after setup.
//  Upstream psel_i dropped before pready_o (protocol violation): the downstream transfer still completes and the response is discarded.
//  New setup is accepted only in IDLE. psel_i/penable_i are ignored in other states.
//  Error status: on error, if !err_valid_o, latch err_addr_o/err_type_o and set err_valid_o.
//   Subsequent errors do not overwrite.
//   err_clr_i clears the flag. A simultaneous new error wins: the flag stays 1 with the new addr/type.
//  Downstream slave pslverr is passed upstream only and is not recorded in err_*.
// TESTING
//  Read port 2 (0x1A10_2000..0x1A10_2FFF) at 0x1A10_2004, zero-wait, prdata=0x1234
//   -> psel_o=0x004, pready_o in cycle 3, prdata_o=0x1234, pslverr_o=0.
//  Write 0xCAFE to port 0 with 4 wait states -> pwdata_o=0xCAFE held stable, pready_o at cycle 7.
//  Access unmapped 0x3000_0000 -> psel_o stays 0, pready_o next cycle, pslverr_o=1, prdata_o=0xDEAD_BEEF.
//   err_valid_o=1, err_type_o=0, err_addr_o=0x3000_0000.
//  TIMEOUT_CYCLES=8, slave never ready -> psel_o drops after 8 ACCESS cycles, pslverr_o=1, err_type_o=1.
//   Then err_clr_i together with a second miss -> err_valid_o=1, err_addr_o = second address.
//  Overlapping ranges on ports 1 and 3 -> port 1 selected.
//  rst_ni low during DACCESS -> all outputs 0 at once. Next access completes normally.
//  Back-to-back reads to ports 0,1,2 -> one-hot psel_o every transfer, no lost or duplicated pready_o.

Source files
------------

// File: rtl/apb_node_watchdog.sv
// apb_node_watchdog: APB 1-to-N node with address decode, PREADY watchdog, default error slave and sticky error status
module apb_node_watchdog #(
    parameter int          NB_MASTER      = 9,
    parameter int          APB_ADDR_WIDTH = 32,
    parameter int          APB_DATA_WIDTH = 32,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [APB_ADDR_WIDTH-1:0]           paddr_i,
    input  logic [APB_DATA_WIDTH-1:0]           pwdata_i,
    input  logic                                pwrite_i,
    input  logic                                psel_i,
    input  logic                                penable_i,
    output logic [APB_DATA_WIDTH-1:0]           prdata_o,
    output logic                                pready_o,
    output logic                                pslverr_o,
    input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] start_addr_i,
    input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] end_addr_i,
    output logic [APB_ADDR_WIDTH-1:0]           paddr_o,
    output logic [APB_DATA_WIDTH-1:0]           pwdata_o,
    output logic                                pwrite_o,
    output logic [NB_MASTER-1:0]                psel_o,
    output logic                                penable_o,
    input  logic [NB_MASTER*APB_DATA_WIDTH-1:0] prdata_i,
    input  logic [NB_MASTER-1:0]                pready_i,
    input  logic [NB_MASTER-1:0]                pslverr_i,
    output logic                                err_valid_o,
    output logic                                err_type_o,
    output logic [APB_ADDR_WIDTH-1:0]           err_addr_o,
    input  logic                                err_clr_i
);
    localparam int AW = APB_ADDR_WIDTH;
    localparam int DW = APB_DATA_WIDTH;
    localparam int IW = NB_MASTER > 1 ? $clog2(NB_MASTER) : 1;
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [DW-1:0] ERR_DATA = DW'(ERR_RDATA);
    localparam logic [1:0] IDLE = 2'd0, DSETUP = 2'd1, DACCESS = 2'd2, RESP = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d, err_addr_q, err_addr_d;
    logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic          write_q, write_d, slverr_q, slverr_d;
    logic [IW-1:0] idx_q, idx_d, hit_idx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_valid_q, err_valid_d, err_type_q, err_type_d;
    logic          hit, setup, sel_ready, timeout, err_evt, err_latch;

    // Range decode; scanning downwards lets the lowest matching port win
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NB_MASTER - 1; i >= 0; i--)
            if (paddr_i >= start_addr_i[i*AW +: AW] && paddr_i <= end_addr_i[i*AW +: AW]) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
    end

    assign setup     = state_q == IDLE && psel_i && !penable_i;
    assign sel_ready = pready_i[idx_q];
    assign timeout   = TIMEOUT_CYCLES != 0 && cnt_q == CW'(TIMEOUT_CYCLES - 1);
    assign err_evt   = (setup && !hit) || (state_q == DACCESS && !sel_ready && timeout);
    assign err_latch = err_evt && (!err_valid_q || err_clr_i);

    // Transfer FSM next state plus captured request/response
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        write_d  = write_q;
        idx_d    = idx_q;
        rdata_d  = rdata_q;
        slverr_d = slverr_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: if (setup) begin
                addr_d   = paddr_i;
                wdata_d  = pwdata_i;
                write_d  = pwrite_i;
                idx_d    = hit_idx;
                rdata_d  = ERR_DATA;
                slverr_d = 1'b1;
                state_d  = hit ? DSETUP : RESP;
            end
            DSETUP: begin
                state_d = DACCESS;
                cnt_d   = '0;
            end
            DACCESS: if (sel_ready) begin
                rdata_d  = prdata_i[idx_q*DW +: DW];
                slverr_d = pslverr_i[idx_q];
                state_d  = RESP;
            end else if (timeout) begin
                rdata_d  = ERR_DATA;
                slverr_d = 1'b1;
                state_d  = RESP;
            end else begin
                cnt_d = cnt_q == '1 ? cnt_q : cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sticky error status; a fresh error beats a simultaneous clear
    always_comb begin
        err_valid_d = err_evt || (err_valid_q && !err_clr_i);
        err_addr_d  = err_latch ? (state_q == IDLE ? paddr_i : addr_q) : err_addr_q;
        err_type_d  = err_latch ? state_q != IDLE : err_type_q;
    end

    // State registers with asynchronous abort on reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            idx_q       <= '0;
            rdata_q     <= '0;
            slverr_q    <= 1'b0;
            cnt_q       <= '0;
            err_valid_q <= 1'b0;
            err_type_q  <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            idx_q       <= idx_d;
            rdata_q     <= rdata_d;
            slverr_q    <= slverr_d;
            cnt_q       <= cnt_d;
            err_valid_q <= err_valid_d;
            err_type_q  <= err_type_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign paddr_o     = addr_q;
    assign pwdata_o    = wdata_q;
    assign pwrite_o    = write_q;
    assign psel_o      = (state_q == DSETUP || state_q == DACCESS) ? NB_MASTER'(1) << idx_q : '0;
    assign penable_o   = state_q == DACCESS;
    assign pready_o    = state_q == RESP;
    assign prdata_o    = pready_o ? rdata_q : '0;
    assign pslverr_o   = pready_o && slverr_q;
    assign err_valid_o = err_valid_q;
    assign err_type_o  = err_type_q;
    assign err_addr_o  = err_addr_q;
endmodule
